// File: rtl/sdp_ram_frame_reader.sv
// rtl/sdp_ram_frame_reader.sv - read-side frame streamer for the 2048x8 simple-dual-port RAM buffer
// Reads LEN bytes from BASE_ADDR with circular wrap and presents them as a valid/ready stream.
module sdp_ram_frame_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W:0]   LEN,
  output logic [ADDR_W-1:0] RADDR,
  output logic              REN,
  input  logic [DATA_W-1:0] RD,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  output logic              DOUT_LAST,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rem_issue;
  logic [ADDR_W:0]   rem_out;
  logic [ADDR_W:0]   sat_len;
  logic              inflight;
  logic              empty_frame;
  logic              done_q;

  logic [DATA_W-1:0] fifo_mem [0:1];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;

  logic              pop;
  logic              issue;
  logic              last_pop;
  logic [2:0]        credit;

  assign sat_len = (LEN > DEPTH) ? DEPTH : LEN;

  assign DOUT_VALID = (fifo_count != 2'd0);
  assign DOUT       = DOUT_VALID ? fifo_mem[rd_ptr] : '0;
  assign DOUT_LAST  = DOUT_VALID && (rem_out == CNT_ONE);
  assign BUSY       = (state != S_IDLE);
  assign DONE       = done_q;
  assign RADDR      = addr;
  assign REN        = issue;

  assign pop      = DOUT_VALID && DOUT_READY;
  assign last_pop = pop && (rem_out == CNT_ONE);

  // Bytes already held or on their way back from the RAM, after this cycle's pop;
  // keeping this below 2 means the 2-entry FIFO can always absorb the returning byte.
  assign credit = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue  = (state == S_READ) && (rem_issue != CNT_ZERO) && (credit < 3'd2);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_nxt = (sat_len == CNT_ZERO) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        if (issue && (rem_issue == CNT_ONE)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_pop) begin
          state_nxt = S_FIN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      addr        <= '0;
      rem_issue   <= '0;
      rem_out     <= '0;
      inflight    <= 1'b0;
      empty_frame <= 1'b0;
      done_q      <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      state <= state_nxt;

      if ((state == S_IDLE) && START) begin
        addr        <= BASE_ADDR;
        rem_issue   <= sat_len;
        rem_out     <= sat_len;
        empty_frame <= (sat_len == CNT_ZERO);
      end else begin
        if (issue) begin
          addr      <= addr + ADDR_ONE;
          rem_issue <= rem_issue - CNT_ONE;
        end
        if (pop) begin
          rem_out <= rem_out - CNT_ONE;
        end
      end

      inflight <= issue;

      if (inflight) begin
        fifo_mem[wr_ptr] <= RD;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};

      // A zero-length frame has no final pop, so its completion pulse follows FIN instead.
      done_q <= last_pop || ((state == S_FIN) && empty_frame);
    end
  end

  assert property (@(posedge CLK) disable iff (RST)
    !(inflight && (fifo_count == 2'd2) && !pop));

endmodule
